// File: rtl/pwm_multi_if.sv
// Bus bundle for pwm_multi: control inputs, shadow-load strobe and PWM outputs.
// Latency: none (wires only). Backpressure: none, the load strobe is always accepted.
// PWM_POLARITY_EN adds the per-channel polarity vector.
interface pwm_multi_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  logic                      enable;
  logic                      load;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0]       polarity;
`endif
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_tick;
  logic                      pending;

`ifdef PWM_POLARITY_EN
  modport master (output enable, load, period, duty, polarity,
                  input  pwm_out, period_tick, pending);
  modport slave  (input  enable, load, period, duty, polarity,
                  output pwm_out, period_tick, pending);
`else
  modport master (output enable, load, period, duty,
                  input  pwm_out, period_tick, pending);
  modport slave  (input  enable, load, period, duty,
                  output pwm_out, period_tick, pending);
`endif
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared period counter; optional PWM_POLARITY_EN inverts channels.
// Latency: pwm_out lags cnt by 1 clock; loads take effect at the next period boundary.
// Backpressure: none, a later load before the boundary simply replaces the earlier one.
module pwm_multi #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic       clk,
  input  logic       rst,
  pwm_multi_if.slave bus
);

  logic [WIDTH-1:0]    sh_period;
  logic [WIDTH-1:0]    act_period;
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    sh_duty  [CHANNELS];
  logic [WIDTH-1:0]    act_duty [CHANNELS];
  logic                pending_q;
  logic [CHANNELS-1:0] pwm_q;
  logic                tick_q;

  logic                running;
  logic                wrap;
  logic                apply;
  logic [CHANNELS-1:0] pwm_nxt;

  assign running = bus.enable && (act_period != '0);
  assign wrap    = running && (cnt == act_period - WIDTH'(1));
  // Disabled or idle counts as a boundary, so nothing is ever left stranded in the shadow.
  assign apply   = wrap || !running;

  always_comb begin
    pwm_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_POLARITY_EN
      pwm_nxt[i] = running ? ((cnt < act_duty[i]) ^ bus.polarity[i]) : bus.polarity[i];
`else
      pwm_nxt[i] = running && (cnt < act_duty[i]);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_period  <= '0;
      act_period <= '0;
      cnt        <= '0;
      pending_q  <= 1'b0;
      pwm_q      <= '0;
      tick_q     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        sh_duty[i]  <= '0;
        act_duty[i] <= '0;
      end
    end else begin
      if (bus.load) begin
        sh_period <= bus.period;
        for (int i = 0; i < CHANNELS; i++)
          sh_duty[i] <= bus.duty[i*WIDTH +: WIDTH];
      end

      // A load coinciding with a boundary bypasses the shadow straight into active.
      if (apply) begin
        act_period <= bus.load ? bus.period : sh_period;
        for (int i = 0; i < CHANNELS; i++)
          act_duty[i] <= bus.load ? bus.duty[i*WIDTH +: WIDTH] : sh_duty[i];
        pending_q <= 1'b0;
      end else if (bus.load) begin
        pending_q <= 1'b1;
      end

      cnt    <= (running && !wrap) ? cnt + WIDTH'(1) : '0;
      pwm_q  <= pwm_nxt;
      tick_q <= wrap;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.period_tick = tick_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: inputs driven and outputs sampled on the falling edge.
module tb_pwm_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  pwm_multi_if #(.WIDTH(32), .CHANNELS(4)) bus ();

  pwm_multi #(.WIDTH(32), .CHANNELS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reset, then load from idle; returns at the falling edge after the load was taken (P1).
  task automatic start(input logic [31:0] p, input logic [127:0] d);
    @(negedge clk);
    rst = 1'b1;
    bus.load = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.period = p;
    bus.duty = d;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    bus.load = 1'b0;
    bus.period = '0;
    bus.duty = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.pwm_out !== 4'b0000 || bus.period_tick !== 1'b0 || bus.pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got pwm=%b tick=%b pend=%b exp pwm=0000 tick=0 pend=0",
               bus.pwm_out, bus.period_tick, bus.pending);
    end
    rst = 1'b0;
    bus.enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.pwm_out !== 4'b0000 || bus.period_tick !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset c=%0d got pwm=%b tick=%b exp 0000/0", k, bus.pwm_out, bus.period_tick);
      end
    end
  endtask

  task automatic test_basic();
    int phase;
    logic [3:0] exp_out;
    start(32'd10, {32'd12, 32'd10, 32'd3, 32'd0});
    for (int k = 2; k <= 31; k++) begin
      @(negedge clk);
      phase = (k - 2) % 10;
      exp_out = {1'b1, 1'b1, (phase < 3), 1'b0};
      checks++;
      if (bus.pwm_out !== exp_out || bus.period_tick !== (phase == 9) || bus.pending !== 1'b0) begin
        failures++;
        $display("FAIL basic k=%0d got pwm=%b tick=%b pend=%b exp pwm=%b tick=%b pend=0",
                 k, bus.pwm_out, bus.period_tick, bus.pending, exp_out, (phase == 9));
      end
    end
  endtask

  task automatic test_update();
    int phase;
    int d;
    logic [3:0] exp_out;
    logic exp_pend;
    start(32'd10, {32'd0, 32'd0, 32'd0, 32'd3});
    for (int k = 2; k <= 21; k++) begin
      @(negedge clk);
      phase = (k - 2) % 10;
      d = (k <= 11) ? 3 : 7;
      exp_out = {3'b000, (phase < d)};
      exp_pend = (k >= 6 && k <= 10);
      checks++;
      if (bus.pwm_out !== exp_out || bus.pending !== exp_pend || bus.period_tick !== (phase == 9)) begin
        failures++;
        $display("FAIL update k=%0d got pwm=%b pend=%b tick=%b exp pwm=%b pend=%b tick=%b",
                 k, bus.pwm_out, bus.pending, bus.period_tick, exp_out, exp_pend, (phase == 9));
      end
      if (k == 5) begin
        bus.duty = {32'd0, 32'd0, 32'd0, 32'd7};
        bus.load = 1'b1;
      end
      if (k == 6) bus.load = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int phase;
    int d;
    logic [3:0] exp_out;
    logic exp_pend;
    start(32'd10, {32'd0, 32'd0, 32'd0, 32'd3});
    for (int k = 2; k <= 31; k++) begin
      @(negedge clk);
      phase = (k - 2) % 10;
      d = (k <= 11) ? 3 : ((k <= 21) ? 2 : 6);
      exp_out = {3'b000, (phase < d)};
      exp_pend = (k >= 4 && k <= 10);
      checks++;
      if (bus.pwm_out !== exp_out || bus.pending !== exp_pend) begin
        failures++;
        $display("FAIL back_to_back k=%0d got pwm=%b pend=%b exp pwm=%b pend=%b",
                 k, bus.pwm_out, bus.pending, exp_out, exp_pend);
      end
      case (k)
        3:  begin bus.duty = {32'd0, 32'd0, 32'd0, 32'd5}; bus.load = 1'b1; end
        6:  begin bus.duty = {32'd0, 32'd0, 32'd0, 32'd2}; bus.load = 1'b1; end
        20: begin bus.duty = {32'd0, 32'd0, 32'd0, 32'd6}; bus.load = 1'b1; end
        4, 7, 21: bus.load = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_shrink();
    int phase;
    int per;
    logic [3:0] exp_out;
    logic exp_pend;
    start(32'd100, {32'd0, 32'd0, 32'd50, 32'd3});
    for (int k = 2; k <= 130; k++) begin
      @(negedge clk);
      if (k <= 101) begin
        per = 100;
        phase = (k - 2) % 100;
      end else begin
        per = 8;
        phase = (k - 102) % 8;
      end
      exp_out = {2'b00, (phase < 50), (phase < 3)};
      exp_pend = (k >= 21 && k <= 100);
      checks++;
      if (bus.pwm_out !== exp_out || bus.period_tick !== (phase == per - 1) || bus.pending !== exp_pend) begin
        failures++;
        $display("FAIL shrink k=%0d got pwm=%b tick=%b pend=%b exp pwm=%b tick=%b pend=%b",
                 k, bus.pwm_out, bus.period_tick, bus.pending, exp_out, (phase == per - 1), exp_pend);
      end
      if (k == 20) begin
        bus.period = 32'd8;
        bus.load = 1'b1;
      end
      if (k == 21) bus.load = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    start(32'd10, {32'd0, 32'd0, 32'd0, 32'd7});
    repeat (5) @(negedge clk);
    checks++;
    if (bus.pwm_out !== 4'b0001) begin
      failures++;
      $display("FAIL reset_mid_pre got pwm=%b exp 0001", bus.pwm_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pwm_out !== 4'b0000 || bus.period_tick !== 1'b0 || bus.pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async got pwm=%b tick=%b pend=%b exp 0000/0/0",
               bus.pwm_out, bus.period_tick, bus.pending);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.pwm_out !== 4'b0000 || bus.period_tick !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_idle c=%0d got pwm=%b tick=%b exp 0000/0", k, bus.pwm_out, bus.period_tick);
      end
    end
    bus.period = 32'd10;
    bus.duty = {32'd0, 32'd0, 32'd0, 32'd7};
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    checks++;
    if (bus.pwm_out !== 4'b0000) begin
      failures++;
      $display("FAIL idle_load_lat1 got pwm=%b exp 0000", bus.pwm_out);
    end
    @(negedge clk);
    checks++;
    if (bus.pwm_out !== 4'b0001) begin
      failures++;
      $display("FAIL idle_load_lat2 got pwm=%b exp 0001", bus.pwm_out);
    end
  endtask

  task automatic test_enable();
    int phase;
    logic [3:0] exp_out;
    start(32'd10, {32'd0, 32'd0, 32'd0, 32'd7});
    repeat (4) @(negedge clk);
    bus.enable = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (bus.pwm_out !== 4'b0000 || bus.period_tick !== 1'b0) begin
        failures++;
        $display("FAIL enable_low j=%0d got pwm=%b tick=%b exp 0000/0", j, bus.pwm_out, bus.period_tick);
      end
    end
    bus.enable = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      phase = j % 10;
      exp_out = {3'b000, (phase < 7)};
      checks++;
      if (bus.pwm_out !== exp_out || bus.period_tick !== (phase == 9)) begin
        failures++;
        $display("FAIL enable_restart j=%0d got pwm=%b tick=%b exp pwm=%b tick=%b",
                 j, bus.pwm_out, bus.period_tick, exp_out, (phase == 9));
      end
    end
  endtask

  task automatic test_period_one();
    start(32'd1, {32'd0, 32'd0, 32'd0, 32'd1});
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.pwm_out !== 4'b0001 || bus.period_tick !== 1'b1) begin
        failures++;
        $display("FAIL period_one k=%0d got pwm=%b tick=%b exp 0001/1", k, bus.pwm_out, bus.period_tick);
      end
    end
  endtask

`ifdef PWM_POLARITY_EN
  task automatic test_polarity();
    int phase;
    logic [3:0] exp_out;
    bus.polarity = 4'b0010;
    start(32'd10, {32'd3, 32'd3, 32'd3, 32'd3});
    for (int k = 2; k <= 11; k++) begin
      @(negedge clk);
      phase = (k - 2) % 10;
      exp_out = {4{phase < 3}} ^ 4'b0010;
      checks++;
      if (bus.pwm_out !== exp_out) begin
        failures++;
        $display("FAIL polarity k=%0d got pwm=%b exp %b", k, bus.pwm_out, exp_out);
      end
    end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pwm_out !== 4'b0010) begin
      failures++;
      $display("FAIL polarity_rest got pwm=%b exp 0010", bus.pwm_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pwm_out !== 4'b0000) begin
      failures++;
      $display("FAIL polarity_reset got pwm=%b exp 0000", bus.pwm_out);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.polarity = 4'b0000;
  endtask
`endif

  initial begin
`ifdef PWM_POLARITY_EN
    bus.polarity = 4'b0000;
`endif
    test_reset();
    test_basic();
    test_update();
    test_back_to_back();
    test_shrink();
    test_reset_mid();
    test_enable();
    test_period_one();
`ifdef PWM_POLARITY_EN
    test_polarity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
